// File: rtl/prog_muxn_if.sv
// Bus bundle for one programmable N-to-1 mux: data inputs, serial config chain
// and status outputs. The chain link (prog_out -> next prog_in) is wired outside.
interface prog_muxn_if #(
  parameter int N_INPUTS = 16
);
  logic [N_INPUTS-1:0] in;
  logic                prog_in;
  logic                prog_en;
  logic                prog_load;
  logic                out;
  logic                prog_out;
  logic                sel_valid;
  logic [7:0]          shift_cnt;

  modport master (
    output in, prog_in, prog_en, prog_load,
    input  out, prog_out, sel_valid, shift_cnt
  );

  modport slave (
    input  in, prog_in, prog_en, prog_load,
    output out, prog_out, sel_valid, shift_cnt
  );
endinterface

// File: rtl/prog_muxn.sv
// Programmable N-to-1 mux whose select is loaded through a serial scan chain
// (MSB-first shift register) and committed atomically with prog_load.
module prog_muxn #(
  parameter int N_INPUTS    = 16,
  parameter int SEL_W       = 4,
  parameter int DEFAULT_SEL = 0,
  parameter int REG_OUT     = 0
) (
  input logic       prog_clk,
  input logic       prog_rst_n,
  prog_muxn_if.slave bus
);

  localparam int          PAD_W   = 1 << SEL_W;
  localparam logic [31:0] N_LIMIT = 32'(N_INPUTS);

  typedef enum logic {IDLE, SHIFT} mode_t;

  mode_t            mode;
  logic [SEL_W-1:0] shreg;
  logic [SEL_W-1:0] shreg_next;
  logic [SEL_W-1:0] shift_val;
  logic [SEL_W-1:0] act_sel;
  logic [SEL_W-1:0] act_sel_next;
  logic [7:0]       cnt;
  logic [7:0]       cnt_next;
  logic [PAD_W-1:0] in_pad;
  logic             sel_ok;
  logic             mux_val;

  // A one-bit select has no retained bits, so the shift just takes prog_in.
  if (SEL_W == 1) begin : g_shift_1
    assign shift_val = bus.prog_in;
  end else begin : g_shift_n
    assign shift_val = {shreg[SEL_W-2:0], bus.prog_in};
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shreg   <= '0;
      act_sel <= SEL_W'(DEFAULT_SEL);
      cnt     <= '0;
    end else begin
      shreg   <= shreg_next;
      act_sel <= act_sel_next;
      cnt     <= cnt_next;
    end
  end

  always_comb begin
    mode         = bus.prog_en ? SHIFT : IDLE;
    shreg_next   = shreg;
    act_sel_next = act_sel;
    cnt_next     = cnt;
    // Commit samples the pre-shift contents even when a shift shares the edge.
    if (bus.prog_load) begin
      act_sel_next = shreg;
    end
    unique case (mode)
      SHIFT: begin
        shreg_next = shift_val;
        if (bus.prog_load) begin
          cnt_next = 8'd1;
        end else if (cnt != 8'hFF) begin
          cnt_next = cnt + 8'd1;
        end
      end
      IDLE: begin
        if (bus.prog_load) begin
          cnt_next = 8'd0;
        end
      end
      default: begin
        shreg_next = shreg;
      end
    endcase
  end

  // Zero-pad the inputs so every select code indexes a real bit.
  always_comb begin
    in_pad = '0;
    for (int i = 0; i < N_INPUTS && i < PAD_W; i++) begin
      in_pad[i] = bus.in[i];
    end
  end

  assign sel_ok  = (32'(act_sel) < N_LIMIT);
  assign mux_val = sel_ok & in_pad[act_sel];

  if (REG_OUT != 0) begin : g_reg_out
    logic out_q;
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
        out_q <= 1'b0;
      end else begin
        out_q <= mux_val;
      end
    end
    assign bus.out = out_q;
  end else begin : g_comb_out
    assign bus.out = mux_val;
  end

  assign bus.prog_out  = shreg[SEL_W-1];
  assign bus.sel_valid = sel_ok;
  assign bus.shift_cnt = cnt;

endmodule

// File: tb/tb_prog_muxn.sv
// Directed bench for prog_muxn: single, chained, non-power-of-two and
// registered-output instances checked through an expected-value queue.
module tb_prog_muxn;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  prog_muxn_if #(.N_INPUTS(16)) if_a ();
  prog_muxn_if #(.N_INPUTS(16)) if_b ();
  prog_muxn_if #(.N_INPUTS(16)) if_c ();
  prog_muxn_if #(.N_INPUTS(12)) if_d ();
  prog_muxn_if #(.N_INPUTS(16)) if_e ();

  assign if_c.prog_in = if_b.prog_out;

  prog_muxn #(.N_INPUTS(16), .SEL_W(4)) u_a (.prog_clk(clk), .prog_rst_n(rst_n), .bus(if_a));
  prog_muxn #(.N_INPUTS(16), .SEL_W(4)) u_head (.prog_clk(clk), .prog_rst_n(rst_n), .bus(if_b));
  prog_muxn #(.N_INPUTS(16), .SEL_W(4)) u_tail (.prog_clk(clk), .prog_rst_n(rst_n), .bus(if_c));
  prog_muxn #(.N_INPUTS(12), .SEL_W(4)) u_d (.prog_clk(clk), .prog_rst_n(rst_n), .bus(if_d));
  prog_muxn #(.N_INPUTS(16), .SEL_W(4), .DEFAULT_SEL(5), .REG_OUT(1)) u_e (
    .prog_clk(clk), .prog_rst_n(rst_n), .bus(if_e));

  typedef struct {
    string      tag;
    logic [7:0] value;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void push_exp(input string tag, input logic [7:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endfunction

  task automatic check_output(input logic [7:0] observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed=%0h expected=<none>", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // unit: 0=a, 1=chain head+tail, 2=d, 3=e
  task automatic drive_edge(input int unit, input logic en, input logic din, input logic load);
    case (unit)
      0: begin if_a.prog_en = en; if_a.prog_in = din; if_a.prog_load = load; end
      1: begin
        if_b.prog_en = en; if_b.prog_in = din; if_b.prog_load = load;
        if_c.prog_en = en; if_c.prog_load = load;
      end
      2: begin if_d.prog_en = en; if_d.prog_in = din; if_d.prog_load = load; end
      default: begin if_e.prog_en = en; if_e.prog_in = din; if_e.prog_load = load; end
    endcase
    tick();
    if_a.prog_en = 1'b0; if_a.prog_load = 1'b0;
    if_b.prog_en = 1'b0; if_b.prog_load = 1'b0;
    if_c.prog_en = 1'b0; if_c.prog_load = 1'b0;
    if_d.prog_en = 1'b0; if_d.prog_load = 1'b0;
    if_e.prog_en = 1'b0; if_e.prog_load = 1'b0;
  endtask

  task automatic commit_nibble(input int unit, input logic [3:0] pat);
    for (int i = 3; i >= 0; i--) begin
      drive_edge(unit, 1'b1, pat[i], 1'b0);
    end
    drive_edge(unit, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin : watchdog
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] bench timed out");
  end

  initial begin : stimulus
    logic [3:0] pat;
    logic [3:0] sh_a;
    logic [7:0] cpat;
    logic [7:0] chain_m;

    rst_n = 1'b0;
    if_a.in = '0; if_a.prog_in = 1'b0; if_a.prog_en = 1'b0; if_a.prog_load = 1'b0;
    if_b.in = '0; if_b.prog_in = 1'b0; if_b.prog_en = 1'b0; if_b.prog_load = 1'b0;
    if_c.in = '0; if_c.prog_en = 1'b0; if_c.prog_load = 1'b0;
    if_d.in = '0; if_d.prog_in = 1'b0; if_d.prog_en = 1'b0; if_d.prog_load = 1'b0;
    if_e.in = '0; if_e.prog_in = 1'b0; if_e.prog_en = 1'b0; if_e.prog_load = 1'b0;
    #12;
    push_exp("a_rst_cnt", 8'd0);   check_output(if_a.shift_cnt);
    push_exp("e_rst_out", 8'd0);   check_output({7'b0, if_e.out});
    push_exp("d_rst_valid", 8'd1); check_output({7'b0, if_d.sel_valid});
    rst_n = 1'b1;
    tick();

    // Post-reset state: select 0 active.
    if_a.in = 16'h0001;
    #1;
    push_exp("a_out_sel0", 8'd1);   check_output({7'b0, if_a.out});
    push_exp("a_prog_out0", 8'd0);  check_output({7'b0, if_a.prog_out});
    push_exp("a_sel_valid", 8'd1);  check_output({7'b0, if_a.sel_valid});
    push_exp("a_cnt0", 8'd0);       check_output(if_a.shift_cnt);

    // Shift 4'hA; out must keep following select 0 until commit.
    pat  = 4'hA;
    sh_a = 4'h0;
    for (int i = 0; i < 4; i++) begin
      drive_edge(0, 1'b1, pat[3-i], 1'b0);
      sh_a = {sh_a[2:0], pat[3-i]};
      push_exp("a_hold_out", 8'd1);           check_output({7'b0, if_a.out});
      push_exp("a_shift_cnt", 8'(i + 1));     check_output(if_a.shift_cnt);
      push_exp("a_shift_po", {7'b0, sh_a[3]}); check_output({7'b0, if_a.prog_out});
    end
    drive_edge(0, 1'b0, 1'b0, 1'b1);
    push_exp("a_cnt_clr", 8'd0); check_output(if_a.shift_cnt);
    if_a.in = 16'h0400; #1;
    push_exp("a_sel10_hi", 8'd1); check_output({7'b0, if_a.out});
    if_a.in = 16'hFBFF; #1;
    push_exp("a_sel10_lo", 8'd0); check_output({7'b0, if_a.out});
    if_a.in = 16'h0001; #1;
    push_exp("a_sel10_b0", 8'd0); check_output({7'b0, if_a.out});

    // Load 5 into shreg, then shift and commit on the same edge.
    pat = 4'h5;
    for (int i = 0; i < 4; i++) begin
      drive_edge(0, 1'b1, pat[3-i], 1'b0);
      sh_a = {sh_a[2:0], pat[3-i]};
    end
    drive_edge(0, 1'b1, 1'b1, 1'b1);
    sh_a = {sh_a[2:0], 1'b1};
    push_exp("a_same_cnt", 8'd1);           check_output(if_a.shift_cnt);
    push_exp("a_same_po", {7'b0, sh_a[3]}); check_output({7'b0, if_a.prog_out});
    if_a.in = 16'h0020; #1;
    push_exp("a_same_sel5", 8'd1); check_output({7'b0, if_a.out});
    if_a.in = 16'h0800; #1;
    push_exp("a_same_notB", 8'd0); check_output({7'b0, if_a.out});

    // Saturation of shift_cnt at 255.
    if_a.prog_en = 1'b1;
    if_a.prog_in = 1'b1;
    repeat (253) tick();
    push_exp("a_cnt254", 8'd254); check_output(if_a.shift_cnt);
    tick();
    push_exp("a_cnt255", 8'd255); check_output(if_a.shift_cnt);
    repeat (46) tick();
    push_exp("a_cnt_sat", 8'd255); check_output(if_a.shift_cnt);
    if_a.prog_en = 1'b0;
    if_a.in = 16'h0020; #1;
    push_exp("a_sel5_kept", 8'd1); check_output({7'b0, if_a.out});

    // Two-element chain: 8'h3C shifted through head into tail.
    cpat    = 8'h3C;
    chain_m = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      drive_edge(1, 1'b1, cpat[i], 1'b0);
      chain_m = {chain_m[6:0], cpat[i]};
      push_exp("chain_po", {6'b0, chain_m[7], chain_m[3]});
      check_output({6'b0, if_c.prog_out, if_b.prog_out});
    end
    drive_edge(1, 1'b0, 1'b0, 1'b1);
    if_b.in = 16'h1000;
    if_c.in = 16'h0008;
    #1;
    push_exp("head_selC", 8'd1); check_output({7'b0, if_b.out});
    push_exp("tail_sel3", 8'd1); check_output({7'b0, if_c.out});
    if_b.in = 16'h0008;
    if_c.in = 16'h1000;
    #1;
    push_exp("head_not3", 8'd0); check_output({7'b0, if_b.out});
    push_exp("tail_notC", 8'd0); check_output({7'b0, if_c.out});

    // Twelve-input instance: out-of-range and top legal selects.
    commit_nibble(2, 4'hD);
    if_d.in = 12'hFFF; #1;
    push_exp("d_selD_valid", 8'd0); check_output({7'b0, if_d.sel_valid});
    push_exp("d_selD_out", 8'd0);   check_output({7'b0, if_d.out});
    commit_nibble(2, 4'hB);
    if_d.in = 12'h800; #1;
    push_exp("d_selB_valid", 8'd1); check_output({7'b0, if_d.sel_valid});
    push_exp("d_selB_hi", 8'd1);    check_output({7'b0, if_d.out});
    if_d.in = 12'h7FF; #1;
    push_exp("d_selB_lo", 8'd0);    check_output({7'b0, if_d.out});

    // Registered output: one-edge latency from in.
    commit_nibble(3, 4'h2);
    if_e.in = 16'h0000;
    tick();
    push_exp("e_out_low", 8'd0); check_output({7'b0, if_e.out});
    if_e.in = 16'h0004; #1;
    push_exp("e_out_lag", 8'd0); check_output({7'b0, if_e.out});
    tick();
    push_exp("e_out_rise", 8'd1); check_output({7'b0, if_e.out});

    // Reset in the middle of a shift.
    if_a.in = 16'h0001; #1;
    push_exp("a_pre_rst", 8'd0); check_output({7'b0, if_a.out});
    drive_edge(3, 1'b1, 1'b1, 1'b0);
    drive_edge(3, 1'b1, 1'b1, 1'b0);
    push_exp("e_mid_cnt", 8'd2);  check_output(if_e.shift_cnt);
    push_exp("e_mid_po", 8'd1);   check_output({7'b0, if_e.prog_out});
    push_exp("e_mid_out", 8'd1);  check_output({7'b0, if_e.out});
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("e_rst_cnt", 8'd0);  check_output(if_e.shift_cnt);
    push_exp("e_rst_po", 8'd0);   check_output({7'b0, if_e.prog_out});
    push_exp("e_rst_oreg", 8'd0); check_output({7'b0, if_e.out});
    push_exp("a_rst_sel0", 8'd1); check_output({7'b0, if_a.out});
    #3;
    rst_n = 1'b1;
    if_e.in = 16'h0020;
    tick();
    push_exp("e_default_sel", 8'd1); check_output({7'b0, if_e.out});

    // Shift restarts from an all-zero register after reset.
    drive_edge(3, 1'b1, 1'b1, 1'b0);
    drive_edge(3, 1'b1, 1'b0, 1'b0);
    drive_edge(3, 1'b1, 1'b0, 1'b0);
    push_exp("e_restart_po3", 8'd0); check_output({7'b0, if_e.prog_out});
    drive_edge(3, 1'b1, 1'b0, 1'b0);
    push_exp("e_restart_po4", 8'd1); check_output({7'b0, if_e.prog_out});
    push_exp("e_restart_cnt", 8'd4); check_output(if_e.shift_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
